stream_mux_2x1_arb: RTL and testbench



---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arb_2.sv | 68 ++++++
 rtl/stream_mux_2x1_arb.sv | 77 +++++++
 tb/tb_stream_mux_2x1_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared selects, default width and output-register states for stream_mux_2x1_arb
package mux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } oreg_state_t;

endpackage

// File: rtl/rr_arb_2.sv
// rtl/rr_arb_2.sv - two-requester round-robin arbiter, packet lock under STREAM_MUX_PKT_LOCK_EN
module rr_arb_2
  import mux_pkg::*;
#(
  parameter int INIT_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [1:0] last,
`endif
  output logic [1:0] grant
);

  localparam logic INIT_SEL = (INIT_PRIO != 0) ? SEL_B : SEL_A;

  logic prio;
  logic win;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic lock;
  logic lock_idx;
`endif

  // One-hot grant: a lone requester wins outright, a tie goes to prio.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (prio == SEL_B) ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    // While a packet is open only its owner can be granted, even across gaps.
    if (lock) begin
      grant = (lock_idx == SEL_B) ? {req[SEL_B], 1'b0} : {1'b0, req[SEL_A]};
    end
`endif
  end

  assign win = grant[SEL_B];

  // Pointer (and lock) advance only on an accepted word; the winner drops to lower priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= INIT_SEL;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock     <= 1'b0;
      lock_idx <= SEL_A;
`endif
    end else if (advance) begin
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (last[win]) begin
        prio <= ~win;
        lock <= 1'b0;
      end else begin
        lock     <= 1'b1;
        lock_idx <= win;
      end
`else
      prio <= ~win;
`endif
    end
  end

endmodule

// File: rtl/stream_mux_2x1_arb.sv
// rtl/stream_mux_2x1_arb.sv - registered round-robin 2:1 stream mux; STREAM_MUX_PKT_LOCK_EN adds packet lock
module stream_mux_2x1_arb
  import mux_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int INIT_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic              a_last,
  input  logic              b_last,
  output logic              y_last,
`endif
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_sel,
  input  logic              y_ready
);

  oreg_state_t state;
  logic [1:0]  grant;
  logic        en;
  logic        load;

  rr_arb_2 #(
    .INIT_PRIO(INIT_PRIO)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({b_valid, a_valid}),
    .advance(load),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .last   ({b_last, a_last}),
`endif
    .grant  (grant)
  );

  // Register can take a word when empty or being drained; nothing is accepted during reset.
  assign en      = rst_n && ((state == EMPTY) || y_ready);
  assign a_ready = en && grant[SEL_A];
  assign b_ready = en && grant[SEL_B];
  assign load    = en && (grant != 2'b00);
  assign y_valid = (state == FULL);

  // Output register FSM: load fills (or refills on drain), drain alone empties, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      y_data <= '0;
      y_sel  <= SEL_A;
`ifdef STREAM_MUX_PKT_LOCK_EN
      y_last <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: if (load) state <= FULL;
        FULL:  if (y_ready && !load) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (load) begin
        y_sel  <= grant[SEL_B];
        y_data <= grant[SEL_B] ? b_data : a_data;
`ifdef STREAM_MUX_PKT_LOCK_EN
        y_last <= grant[SEL_B] ? b_last : a_last;
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_2x1_arb.sv
// tb/tb_stream_mux_2x1_arb.sv - directed self-checking bench for stream_mux_2x1_arb
module tb_stream_mux_2x1_arb;

  logic       clk;
  logic       rst_n;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, y_valid, y_sel;
  logic [7:0] y_data;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic       a_last, b_last, y_last;
`endif

  int vectors;
  int miscompares;

  stream_mux_2x1_arb #(.DATA_W(8), .INIT_PRIO(0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_ready(b_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .a_last (a_last),
    .b_last (b_last),
    .y_last (y_last),
`endif
    .y_valid(y_valid),
    .y_data (y_data),
    .y_sel  (y_sel),
    .y_ready(y_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
    a_data = 8'h00; b_data = 8'h00;
`ifdef STREAM_MUX_PKT_LOCK_EN
    a_last = 1'b1; b_last = 1'b1;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] tog [3];
    tog[0] = 8'hC3; tog[1] = 8'h5A; tog[2] = 8'hFF;
    rst_n = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    a_last = 1'b1; b_last = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      a_valid = i[0]; b_valid = 1'b1; y_ready = ~i[0];
      a_data = tog[i]; b_data = ~tog[i];
      tick();
      vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
      vectors++; if (y_data !== 8'h00) begin miscompares++; $display("FAIL reset_y_data: got %h want 00", y_data); end
      vectors++; if (y_sel !== 1'b0) begin miscompares++; $display("FAIL reset_y_sel: got %b want 0", y_sel); end
      vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_readys: got %b want 00", {a_ready, b_ready}); end
    end
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB; y_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL reset_first_grant: got %b want 10", {a_ready, b_ready}); end
    tick();
    vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b0, 8'hAA}) begin miscompares++; $display("FAIL reset_first_load: got %b %b %h want 1 0 aa", y_valid, y_sel, y_data); end
  endtask

  task automatic test_single_source();
    logic [7:0] d;
    apply_reset();
    b_valid = 1'b0; y_ready = 1'b1; a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 + 8'(i);
      a_data = d;
      #1;
      vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL single_a_ready[%0d]: got %b want 1", i, a_ready); end
      tick();
      vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b0, d}) begin miscompares++; $display("FAIL single_y[%0d]: got %b %b %h want 1 0 %h", i, y_valid, y_sel, y_data, d); end
    end
    a_valid = 1'b0;
    tick();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain_empty: got %b want 0", y_valid); end
  endtask

  task automatic test_b_only();
    logic [7:0] d [2];
    d[0] = 8'hFF; d[1] = 8'h00;
    apply_reset();
    a_valid = 1'b0; b_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b_data = d[i];
      tick();
      vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b1, d[i]}) begin miscompares++; $display("FAIL b_only_y[%0d]: got %b %b %h want 1 1 %h", i, y_valid, y_sel, y_data, d[i]); end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_contention();
    logic [7:0] exp_d [4];
    logic       exp_s [4];
    exp_d[0] = 8'hAA; exp_d[1] = 8'hBB; exp_d[2] = 8'hAA; exp_d[3] = 8'hBB;
    exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB; y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, exp_s[i], exp_d[i]}) begin miscompares++; $display("FAIL contention_y[%0d]: got %b %b %h want 1 %b %h", i, y_valid, y_sel, y_data, exp_s[i], exp_d[i]); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h5A; b_data = 8'h66; y_ready = 1'b0;
    tick();
    a_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b0, 8'h5A}) begin miscompares++; $display("FAIL stall_hold[%0d]: got %b %b %h want 1 0 5a", i, y_valid, y_sel, y_data); end
      vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL stall_readys[%0d]: got %b want 00", i, {a_ready, b_ready}); end
      tick();
    end
    y_ready = 1'b1;
    #1;
    vectors++; if ({a_ready, b_ready} !== 2'b01) begin miscompares++; $display("FAIL stall_release_grant: got %b want 01", {a_ready, b_ready}); end
    tick();
    vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b1, 8'h66}) begin miscompares++; $display("FAIL stall_release_load: got %b %b %h want 1 1 66", y_valid, y_sel, y_data); end
    tick();
    vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b0, 8'h77}) begin miscompares++; $display("FAIL stall_next_load: got %b %b %h want 1 0 77", y_valid, y_sel, y_data); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    a_valid = 1'b1; b_valid = 1'b0; a_data = 8'h3C; y_ready = 1'b1;
    tick();
    vectors++; if ({y_valid, y_data} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL async_preload: got %b %h want 1 3c", y_valid, y_data); end
    b_valid = 1'b1; b_data = 8'hD2; a_data = 8'hC3; y_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({y_valid, y_data} !== {1'b0, 8'h00}) begin miscompares++; $display("FAIL async_drop: got %b %h want 0 00", y_valid, y_data); end
    tick();
    rst_n = 1'b1; y_ready = 1'b1;
    #1;
    vectors++; if ({a_ready, b_ready} !== 2'b10) begin miscompares++; $display("FAIL async_restart_grant: got %b want 10", {a_ready, b_ready}); end
    tick();
    vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b0, 8'hC3}) begin miscompares++; $display("FAIL async_restart_load: got %b %b %h want 1 0 c3", y_valid, y_sel, y_data); end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

`ifdef STREAM_MUX_PKT_LOCK_EN
  task automatic test_pkt_lock();
    apply_reset();
    b_valid = 1'b1; b_data = 8'hB0; b_last = 1'b1; y_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h01; a_last = 1'b0;
    tick();
    vectors++; if ({y_sel, y_data, y_last} !== {1'b0, 8'h01, 1'b0}) begin miscompares++; $display("FAIL lock_beat1: got %b %h %b want 0 01 0", y_sel, y_data, y_last); end
    a_data = 8'h02;
    tick();
    vectors++; if ({y_sel, y_data} !== {1'b0, 8'h02}) begin miscompares++; $display("FAIL lock_beat2: got %b %h want 0 02", y_sel, y_data); end
    a_valid = 1'b0;
    #1;
    vectors++; if ({a_ready, b_ready} !== 2'b00) begin miscompares++; $display("FAIL lock_gap_readys: got %b want 00", {a_ready, b_ready}); end
    tick();
    vectors++; if (y_valid !== 1'b0) begin miscompares++; $display("FAIL lock_gap_empty: got %b want 0", y_valid); end
    a_valid = 1'b1; a_data = 8'h03; a_last = 1'b1;
    tick();
    vectors++; if ({y_valid, y_sel, y_data, y_last} !== {1'b1, 1'b0, 8'h03, 1'b1}) begin miscompares++; $display("FAIL lock_beat3: got %b %b %h %b want 1 0 03 1", y_valid, y_sel, y_data, y_last); end
    a_valid = 1'b0;
    tick();
    vectors++; if ({y_valid, y_sel, y_data} !== {1'b1, 1'b1, 8'hB0}) begin miscompares++; $display("FAIL lock_release_b: got %b %b %h want 1 1 b0", y_valid, y_sel, y_data); end
    b_valid = 1'b0;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
`ifdef STREAM_MUX_PKT_LOCK_EN
    a_last = 1'b1; b_last = 1'b1;
`endif
    #2;
    test_reset();
    test_single_source();
    test_b_only();
    test_contention();
    test_backpressure();
    test_async_reset();
`ifdef STREAM_MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
